// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tl_pkg
// Description : Encodings shared by the traffic-light controller and its
//               upstream stages: secondary-road light states, the sensor
//               debounce FSM states and the queue-count limits.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package tl_pkg;

  // Light state as driven on SR_ctl by smart_tl_ctl
  localparam logic [1:0] LIGHT_DARK   = 2'b00;
  localparam logic [1:0] LIGHT_RED    = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_GREEN  = 2'b11;

  // Loop-sensor debounce states
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMING    = 2'b01,
    OCCUPIED  = 2'b10,
    RELEASING = 2'b11
  } db_state_t;

  // Queue count is an unsigned saturating byte
  localparam int         COUNT_W   = 8;
  localparam logic [7:0] COUNT_MAX = 8'hFF;

endpackage : tl_pkg
`default_nettype wire

// File: rtl/sr_car_counter_if.sv
`default_nettype none
// ============================================================================
// Interface   : sr_car_counter_if
// Description : Sensor/light inputs and count/status outputs of the
//               secondary-road car counter.
// Signals     : arr_sensor   raw loop detector (async, high = car present)
//               SR_ctl       secondary light state fed back from smart_tl_ctl
//               cars_waiting queued car count
//               arr_pulse    one-cycle pulse per accepted arrival
//               dep_pulse    one-cycle pulse per departure
//               overflow     sticky lost-arrival flag
// Modports    : master drives the sensor and light, slave is the counter.
// Revision    : 1.0  initial release
// ============================================================================
interface sr_car_counter_if;
  import tl_pkg::*;

  logic               arr_sensor;
  logic [1:0]         SR_ctl;
  logic [COUNT_W-1:0] cars_waiting;
  logic               arr_pulse;
  logic               dep_pulse;
  logic               overflow;

  modport master (
    output arr_sensor,
    output SR_ctl,
    input  cars_waiting,
    input  arr_pulse,
    input  dep_pulse,
    input  overflow
  );

  modport slave (
    input  arr_sensor,
    input  SR_ctl,
    output cars_waiting,
    output arr_pulse,
    output dep_pulse,
    output overflow
  );

endinterface : sr_car_counter_if
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce
// Description : Two-flop synchroniser on the raw loop sensor followed by a
//               debounce FSM. Emits a single-cycle arrival event when a car
//               has been present for DEBOUNCE_CYCLES synchronised samples.
// Ports       : clk        system clock
//               rst        synchronous active-high reset
//               sensor_raw asynchronous loop detector input
//               arr_evt    single-cycle arrival event (combinational from
//                          FSM state, so the consumer registers it directly)
// Revision    : 1.0  initial release
// ============================================================================
module sensor_debounce
  import tl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic sensor_raw,
  output logic      arr_evt
);

  localparam int                DCNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

  logic              r_sync1;
  logic              r_sync2;
  db_state_t         r_state;
  logic [DCNT_W-1:0] r_dcnt;
  logic              w_s;

  assign w_s = r_sync2;

  // The arrival is recognised on the same edge that moves ARMING->OCCUPIED;
  // exposing it combinationally keeps the count update at D+2 edges latency.
  assign arr_evt = (r_state == ARMING) && w_s && (r_dcnt == DCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= sensor_raw;
      r_sync2 <= r_sync1;
      case (r_state)
        IDLE: begin
          if (w_s) begin
            r_state <= ARMING;
            r_dcnt  <= DCNT_ONE;
          end
        end
        ARMING: begin
          if (!w_s) begin
            r_state <= IDLE;
          end else if (r_dcnt == DCNT_LAST) begin
            r_state <= OCCUPIED;
          end else begin
            r_dcnt <= r_dcnt + DCNT_ONE;
          end
        end
        OCCUPIED: begin
          if (!w_s) begin
            r_state <= RELEASING;
            r_dcnt  <= DCNT_ONE;
          end
        end
        RELEASING: begin
          // A car reappearing before the release completes is the same car
          if (w_s) begin
            r_state <= OCCUPIED;
          end else if (r_dcnt == DCNT_LAST) begin
            r_state <= IDLE;
          end else begin
            r_dcnt <= r_dcnt + DCNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : sensor_debounce
`default_nettype wire

// File: rtl/sr_car_counter.sv
`default_nettype none
// ============================================================================
// Module      : sr_car_counter
// Description : Counts cars queued at the secondary-road light. Arrivals come
//               from a debounced loop sensor; departures occur every
//               DEPART_CYCLES consecutive green cycles. The count saturates
//               at 255 and a lost arrival sets a sticky overflow flag.
// Ports       : clk  system clock
//               rst  synchronous active-high reset
//               bus  sr_car_counter_if.slave (arr_sensor, SR_ctl in;
//                    cars_waiting, arr_pulse, dep_pulse, overflow out)
// Revision    : 1.0  initial release
// ============================================================================
module sr_car_counter
  import tl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPART_CYCLES   = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  sr_car_counter_if.slave bus
);

  localparam int                TCNT_W    = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DEPART_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

  logic               w_arr_evt;
  logic               w_green;
  logic               w_dep_evt;
  logic               w_dep_ok;
  logic [TCNT_W-1:0]  r_tcnt;
  logic [COUNT_W-1:0] r_count;
  logic               r_arr_pulse;
  logic               r_dep_pulse;
  logic               r_overflow;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sensor_debounce (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (bus.arr_sensor),
    .arr_evt    (w_arr_evt)
  );

  assign w_green   = (bus.SR_ctl == LIGHT_GREEN);
  assign w_dep_evt = w_green && (r_tcnt == TCNT_LAST);
  // An empty queue cannot release a car, even if an arrival lands this edge
  assign w_dep_ok  = w_dep_evt && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt      <= '0;
      r_count     <= '0;
      r_arr_pulse <= 1'b0;
      r_dep_pulse <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      // Any non-green cycle restarts the pacing interval
      if (!w_green || w_dep_evt) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + TCNT_ONE;
      end

      r_arr_pulse <= w_arr_evt;
      r_dep_pulse <= w_dep_ok;

      // Arrival with a granted departure cancels out, including at 255,
      // so overflow is only raised by an unmatched arrival at the ceiling.
      if (w_arr_evt && !w_dep_ok) begin
        if (r_count == COUNT_MAX) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else if (!w_arr_evt && w_dep_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign bus.cars_waiting = r_count;
  assign bus.arr_pulse    = r_arr_pulse;
  assign bus.dep_pulse    = r_dep_pulse;
  assign bus.overflow     = r_overflow;

endmodule : sr_car_counter
`default_nettype wire

// File: tb/tb_sr_car_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_car_counter
// Description : Directed self-checking bench for sr_car_counter with default
//               parameters (DEBOUNCE_CYCLES=4, DEPART_CYCLES=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_sr_car_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sr_car_counter_if bus ();

  sr_car_counter #(
    .DEBOUNCE_CYCLES (4),
    .DEPART_CYCLES   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs changed and outputs read 2 time units later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One full car passage with the light red
  task automatic add_car();
    bus.arr_sensor = 1'b1;
    repeat (8) tick();
    bus.arr_sensor = 1'b0;
    repeat (8) tick();
  endtask

  // Arrival event and departure event aligned on the same (6th) edge
  task automatic collide(output logic a, output logic d, output logic [7:0] c, output logic o);
    bus.SR_ctl = 2'b01;
    tick();
    bus.arr_sensor = 1'b1;
    repeat (4) tick();
    bus.SR_ctl = 2'b11;
    repeat (2) tick();
    a = bus.arr_pulse;
    d = bus.dep_pulse;
    c = bus.cars_waiting;
    o = bus.overflow;
    bus.SR_ctl = 2'b01;
    bus.arr_sensor = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    bus.arr_sensor = 1'b0;
    bus.SR_ctl     = 2'b01;
    do_reset();
    checks++; if (bus.cars_waiting !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.cars_waiting); end
    checks++; if (bus.arr_pulse !== 1'b0) begin errors++; $display("FAIL reset_arr_pulse got %b want 0", bus.arr_pulse); end
    checks++; if (bus.dep_pulse !== 1'b0) begin errors++; $display("FAIL reset_dep_pulse got %b want 0", bus.dep_pulse); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
  endtask

  task automatic test_clean_arrival();
    do_reset();
    bus.SR_ctl = 2'b01;
    bus.arr_sensor = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (bus.arr_pulse !== 1'(i == 6)) begin errors++; $display("FAIL arrival_pulse edge %0d got %b want %b", i, bus.arr_pulse, i == 6); end
      checks++; if (bus.cars_waiting !== 8'((i >= 6) ? 1 : 0)) begin errors++; $display("FAIL arrival_count edge %0d got %0d want %0d", i, bus.cars_waiting, (i >= 6) ? 1 : 0); end
    end
    bus.arr_sensor = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (bus.arr_pulse !== 1'b0) begin errors++; $display("FAIL arrival_release_pulse edge %0d got %b want 0", i, bus.arr_pulse); end
    end
    checks++; if (bus.cars_waiting !== 8'd1) begin errors++; $display("FAIL arrival_final got %0d want 1", bus.cars_waiting); end
  endtask

  task automatic test_glitch();
    int pulses;
    do_reset();
    bus.SR_ctl = 2'b01;
    pulses = 0;
    bus.arr_sensor = 1'b1;
    repeat (3) begin tick(); pulses += int'(bus.arr_pulse); end
    bus.arr_sensor = 1'b0;
    repeat (10) begin tick(); pulses += int'(bus.arr_pulse); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    checks++; if (bus.cars_waiting !== 8'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", bus.cars_waiting); end
    // Real car with a 3-sample dip while occupied
    bus.arr_sensor = 1'b1;
    repeat (10) begin tick(); pulses += int'(bus.arr_pulse); end
    bus.arr_sensor = 1'b0;
    repeat (3) begin tick(); pulses += int'(bus.arr_pulse); end
    bus.arr_sensor = 1'b1;
    repeat (10) begin tick(); pulses += int'(bus.arr_pulse); end
    bus.arr_sensor = 1'b0;
    repeat (10) begin tick(); pulses += int'(bus.arr_pulse); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL dip_pulses got %0d want 1", pulses); end
    checks++; if (bus.cars_waiting !== 8'd1) begin errors++; $display("FAIL dip_count got %0d want 1", bus.cars_waiting); end
  endtask

  task automatic test_departure();
    int pulses;
    do_reset();
    bus.SR_ctl = 2'b01;
    repeat (7) add_car();
    checks++; if (bus.cars_waiting !== 8'd7) begin errors++; $display("FAIL preload_count got %0d want 7", bus.cars_waiting); end
    bus.SR_ctl = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (bus.dep_pulse !== 1'(i % 2 == 0)) begin errors++; $display("FAIL depart_pulse green %0d got %b want %b", i, bus.dep_pulse, i % 2 == 0); end
      checks++; if (bus.cars_waiting !== 8'(7 - i / 2)) begin errors++; $display("FAIL depart_count green %0d got %0d want %0d", i, bus.cars_waiting, 7 - i / 2); end
    end
    bus.SR_ctl = 2'b01;
    pulses = 0;
    repeat (6) begin tick(); pulses += int'(bus.dep_pulse); end
    // Green interrupted by yellow and dark must restart the pacing interval
    bus.SR_ctl = 2'b11; tick(); pulses += int'(bus.dep_pulse);
    bus.SR_ctl = 2'b10; tick(); pulses += int'(bus.dep_pulse);
    bus.SR_ctl = 2'b11; tick(); pulses += int'(bus.dep_pulse);
    bus.SR_ctl = 2'b00; tick(); pulses += int'(bus.dep_pulse);
    bus.SR_ctl = 2'b11; tick(); pulses += int'(bus.dep_pulse);
    bus.SR_ctl = 2'b01;
    repeat (3) begin tick(); pulses += int'(bus.dep_pulse); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL frozen_pulses got %0d want 0", pulses); end
    checks++; if (bus.cars_waiting !== 8'd2) begin errors++; $display("FAIL frozen_count got %0d want 2", bus.cars_waiting); end
  endtask

  task automatic test_simultaneous();
    logic a, d, o;
    logic [7:0] c;
    do_reset();
    bus.SR_ctl = 2'b01;
    repeat (3) add_car();
    collide(a, d, c, o);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL collide3_arr got %b want 1", a); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL collide3_dep got %b want 1", d); end
    checks++; if (c !== 8'd3) begin errors++; $display("FAIL collide3_count got %0d want 3", c); end
    do_reset();
    collide(a, d, c, o);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL collide0_arr got %b want 1", a); end
    checks++; if (d !== 1'b0) begin errors++; $display("FAIL collide0_dep got %b want 0", d); end
    checks++; if (c !== 8'd1) begin errors++; $display("FAIL collide0_count got %0d want 1", c); end
  endtask

  task automatic test_saturation();
    logic a, d, o;
    logic [7:0] c;
    do_reset();
    bus.SR_ctl = 2'b01;
    repeat (255) add_car();
    checks++; if (bus.cars_waiting !== 8'd255) begin errors++; $display("FAIL sat255_count got %0d want 255", bus.cars_waiting); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sat255_overflow got %b want 0", bus.overflow); end
    collide(a, d, c, o);
    checks++; if ({a, d} !== 2'b11) begin errors++; $display("FAIL collide255_pulses got %b want 11", {a, d}); end
    checks++; if (c !== 8'd255) begin errors++; $display("FAIL collide255_count got %0d want 255", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL collide255_overflow got %b want 0", o); end
    // 256th arrival with no departure: lost
    bus.arr_sensor = 1'b1;
    repeat (6) tick();
    checks++; if (bus.arr_pulse !== 1'b1) begin errors++; $display("FAIL sat256_pulse got %b want 1", bus.arr_pulse); end
    checks++; if (bus.cars_waiting !== 8'd255) begin errors++; $display("FAIL sat256_count got %0d want 255", bus.cars_waiting); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL sat256_overflow got %b want 1", bus.overflow); end
    repeat (2) tick();
    bus.arr_sensor = 1'b0;
    repeat (8) tick();
    bus.SR_ctl = 2'b11;
    repeat (2) tick();
    checks++; if (bus.dep_pulse !== 1'b1) begin errors++; $display("FAIL sat_dep_pulse got %b want 1", bus.dep_pulse); end
    bus.SR_ctl = 2'b01;
    repeat (4) tick();
    checks++; if (bus.cars_waiting !== 8'd254) begin errors++; $display("FAIL sat_dep_count got %0d want 254", bus.cars_waiting); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", bus.overflow); end
    do_reset();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL sat_reset_overflow got %b want 0", bus.overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.SR_ctl = 2'b01;
    repeat (20) add_car();
    checks++; if (bus.cars_waiting !== 8'd20) begin errors++; $display("FAIL mid_preload got %0d want 20", bus.cars_waiting); end
    bus.arr_sensor = 1'b1;
    repeat (3) tick();
    checks++; if (bus.cars_waiting !== 8'd20) begin errors++; $display("FAIL mid_pending got %0d want 20", bus.cars_waiting); end
    rst = 1'b1;
    tick();
    checks++; if ({bus.cars_waiting, bus.arr_pulse, bus.dep_pulse, bus.overflow} !== 11'd0) begin
      errors++; $display("FAIL mid_reset_outputs got %0d/%b/%b/%b want 0/0/0/0", bus.cars_waiting, bus.arr_pulse, bus.dep_pulse, bus.overflow);
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (bus.cars_waiting !== 8'((i >= 6) ? 1 : 0)) begin errors++; $display("FAIL mid_recount edge %0d got %0d want %0d", i, bus.cars_waiting, (i >= 6) ? 1 : 0); end
      checks++; if (bus.arr_pulse !== 1'(i == 6)) begin errors++; $display("FAIL mid_recount_pulse edge %0d got %b want %b", i, bus.arr_pulse, i == 6); end
    end
    bus.arr_sensor = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.arr_sensor = 1'b0;
    bus.SR_ctl = 2'b01;
    test_reset();
    test_clean_arrival();
    test_glitch();
    test_departure();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sr_car_counter
`default_nettype wire
